ftoi_pipe: RTL and testbench

- Parametrised, pipelined float32-to-integer converter.
- Successor to the single-cycle FPU convert path. Adds:
  - selectable integer width;
  - signed and unsigned modes;
  - five rounding modes;
  - a configurable pipeline depth behind a stallable valid/ready handshake.
- Sits in the FPU execution unit between the issue stage and the FPU writeback arbiter.

---
 rtl/ftoi_pipe.sv | 152 +++++++++++++++
 tb/tb_ftoi_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/ftoi_pipe.sv
// Pipelined float32 -> INT_W integer converter with five rounding modes and a stallable valid/ready pipe.
// Define FTOI_FLAGS_EN to add the registered {invalid, inexact} flags port.
module ftoi_pipe #(
  parameter int INT_W  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [2:0]       rm,
  input  logic             is_unsigned,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] y
`ifdef FTOI_FLAGS_EN
  ,
  output logic [1:0]       flags
`endif
);

  localparam int PW = INT_W + 26;
  localparam int RW = INT_W + 2;
  localparam logic [RW-1:0] POS_LIM = {3'b000, {(INT_W-1){1'b1}}};
  localparam logic [RW-1:0] NEG_LIM = {3'b001, {(INT_W-1){1'b0}}};
  localparam logic [RW-1:0] U_LIM   = {2'b01, {INT_W{1'b0}}};
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic signed [9:0] E_MAX = 10'(INT_W);

  logic              sgn;
  logic [7:0]        ex;
  logic [22:0]       man;
  logic signed [9:0] exp_unb;
  logic              is_zero, is_nan, special, tiny;
  logic [6:0]        shamt;
  logic [PW-1:0]     prod;
  logic [INT_W:0]    mag_int;
  logic              guard, rnd, stk, inexact_raw, inc;
  logic [RW-1:0]     rounded;
  logic              ovf_max, ovf_low;
  logic [INT_W-1:0]  y_c;

  assign sgn = x[31];
  assign ex  = x[30:23];
  assign man = x[22:0];

  // prod holds the magnitude as fixed point with 25 fraction bits: guard, round, then 23 sticky bits
  always_comb begin
    exp_unb = $signed({2'b00, ex}) - 10'sd127;
    is_zero = (ex == 8'd0);
    is_nan  = (ex == 8'hFF) && (man != 23'd0);
    tiny    = exp_unb < -10'sd2;
    special = (ex == 8'hFF) || (exp_unb > E_MAX);
    shamt   = 7'(exp_unb + 10'sd2);
    prod    = PW'({1'b1, man}) << shamt;
    if (tiny) begin
      mag_int = '0;
      guard   = 1'b0;
      rnd     = 1'b0;
      stk     = 1'b1;
    end else begin
      mag_int = prod[PW-1:25];
      guard   = prod[24];
      rnd     = prod[23];
      stk     = |prod[22:0];
    end
    inexact_raw = !is_zero && (guard || rnd || stk);
    case (rm)
      3'b001:  inc = 1'b0;
      3'b010:  inc = sgn && inexact_raw;
      3'b011:  inc = !sgn && inexact_raw;
      3'b100:  inc = guard;
      default: inc = guard && (rnd || stk || mag_int[0]);
    endcase
    rounded = RW'(mag_int) + RW'(inc);
    if (is_unsigned) begin
      ovf_max = is_nan || (!sgn && (special || rounded >= U_LIM));
      ovf_low = !is_nan && sgn && (special || rounded != '0);
    end else begin
      ovf_max = is_nan || (!sgn && (special || rounded > POS_LIM));
      ovf_low = !is_nan && sgn && (special || rounded > NEG_LIM);
    end
    if (is_zero)      y_c = '0;
    else if (ovf_max) y_c = is_unsigned ? '1 : INT_MAX;
    else if (ovf_low) y_c = is_unsigned ? '0 : INT_MIN;
    else if (sgn)     y_c = -rounded[INT_W-1:0];
    else              y_c = rounded[INT_W-1:0];
  end

  logic              advance;
  logic [STAGES-1:0] valid_q, valid_d;
  logic [INT_W-1:0]  y_q [STAGES];
  logic [INT_W-1:0]  y_d [STAGES];

  assign advance   = !valid_q[STAGES-1] || out_ready;
  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign y         = y_q[STAGES-1];

  always_comb begin
    valid_d = valid_q;
    y_d     = y_q;
    if (advance) begin
      valid_d[0] = in_valid;
      y_d[0]     = y_c;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        y_d[i]     = y_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) y_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < STAGES; i++) y_q[i] <= y_d[i];
    end
  end

`ifdef FTOI_FLAGS_EN
  logic       inv_c;
  logic [1:0] flags_c;
  logic [1:0] flags_q [STAGES];
  logic [1:0] flags_d [STAGES];

  assign inv_c   = !is_zero && (ovf_max || ovf_low);
  assign flags_c = {inv_c, inexact_raw && !inv_c};
  assign flags   = flags_q[STAGES-1];

  always_comb begin
    flags_d = flags_q;
    if (advance) begin
      flags_d[0] = flags_c;
      for (int i = 1; i < STAGES; i++) flags_d[i] = flags_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < STAGES; i++) flags_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) flags_q[i] <= flags_d[i];
    end
  end
`endif

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe: a 32-bit/2-stage instance and a 64-bit/1-stage instance.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;

  logic        iv_a = 1'b0, rdy_a, u_a = 1'b0, ov_a, or_a = 1'b1;
  logic [31:0] x_a = '0, y_a;
  logic [2:0]  rm_a = '0;
  logic        iv_b = 1'b0, rdy_b, u_b = 1'b0, ov_b, or_b = 1'b1;
  logic [31:0] x_b = '0;
  logic [63:0] y_b;
  logic [2:0]  rm_b = '0;
`ifdef FTOI_FLAGS_EN
  logic [1:0]  fl_a, fl_b;
`endif

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ftoi_pipe #(.INT_W(32), .STAGES(2)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(iv_a), .in_ready(rdy_a), .x(x_a), .rm(rm_a),
    .is_unsigned(u_a), .out_valid(ov_a), .out_ready(or_a), .y(y_a)
`ifdef FTOI_FLAGS_EN
    , .flags(fl_a)
`endif
  );

  ftoi_pipe #(.INT_W(64), .STAGES(1)) dut64 (
    .clk(clk), .rstn(rstn), .in_valid(iv_b), .in_ready(rdy_b), .x(x_b), .rm(rm_b),
    .is_unsigned(u_b), .out_valid(ov_b), .out_ready(or_b), .y(y_b)
`ifdef FTOI_FLAGS_EN
    , .flags(fl_b)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_asrt++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic conv32(input logic [31:0] xv, input logic [2:0] rmv, input logic uns,
                        input logic [31:0] ey, input logic [1:0] ef, input string tag);
    @(negedge clk);
    x_a = xv; rm_a = rmv; u_a = uns; iv_a = 1'b1; or_a = 1'b1;
    @(negedge clk);
    iv_a = 1'b0;
    chk({tag, "_lat1"}, 64'(ov_a), 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(ov_a), 64'd1);
    chk({tag, "_y"}, 64'(y_a), 64'(ey));
`ifdef FTOI_FLAGS_EN
    chk({tag, "_flags"}, 64'(fl_a), 64'(ef));
`endif
  endtask

  task automatic conv64(input logic [31:0] xv, input logic [2:0] rmv, input logic uns,
                        input logic [63:0] ey, input logic [1:0] ef, input string tag);
    @(negedge clk);
    x_b = xv; rm_b = rmv; u_b = uns; iv_b = 1'b1; or_b = 1'b1;
    @(negedge clk);
    iv_b = 1'b0;
    chk({tag, "_valid"}, 64'(ov_b), 64'd1);
    chk({tag, "_y"}, y_b, ey);
`ifdef FTOI_FLAGS_EN
    chk({tag, "_flags"}, 64'(fl_b), 64'(ef));
`endif
  endtask

  logic [31:0] ops [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                           32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};

  initial begin
    int          idx, nout, first_out;
    logic        stalled_prev, saw_block;
    logic [31:0] y_hold;

    #1;
    chk("rst_ov32", 64'(ov_a), 64'd0);
    chk("rst_y32", 64'(y_a), 64'd0);
    chk("rst_ov64", 64'(ov_b), 64'd0);
    chk("rst_y64", y_b, 64'd0);
`ifdef FTOI_FLAGS_EN
    chk("rst_fl32", 64'(fl_a), 64'd0);
`endif
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rel_rdy32", 64'(rdy_a), 64'd1);
    chk("rel_rdy64", 64'(rdy_b), 64'd1);

    // 32-bit signed/unsigned directed conversions; flags are {invalid, inexact}
    conv32(32'h40200000, 3'b000, 1'b0, 32'h00000002, 2'b01, "rne_2p5");
    conv32(32'h40200000, 3'b100, 1'b0, 32'h00000003, 2'b01, "rmm_2p5");
    conv32(32'h40600000, 3'b000, 1'b0, 32'h00000004, 2'b01, "rne_3p5");
    conv32(32'h3F000000, 3'b000, 1'b0, 32'h00000000, 2'b01, "rne_0p5");
    conv32(32'hBFC00000, 3'b010, 1'b0, 32'hFFFFFFFE, 2'b01, "rdn_m1p5");
    conv32(32'hBFC00000, 3'b001, 1'b0, 32'hFFFFFFFF, 2'b01, "rtz_m1p5");
    conv32(32'hBFC00000, 3'b011, 1'b0, 32'hFFFFFFFF, 2'b01, "rup_m1p5");
    conv32(32'hBFC00000, 3'b111, 1'b0, 32'hFFFFFFFE, 2'b01, "rm7_m1p5");
    conv32(32'h3F800000, 3'b000, 1'b0, 32'h00000001, 2'b00, "one");
    conv32(32'hC2F60000, 3'b000, 1'b0, 32'hFFFFFF85, 2'b00, "m123");
    conv32(32'h3E800000, 3'b011, 1'b0, 32'h00000001, 2'b01, "rup_0p25");
    conv32(32'h3D800000, 3'b011, 1'b0, 32'h00000001, 2'b01, "rup_tiny");
    conv32(32'h3D800000, 3'b000, 1'b0, 32'h00000000, 2'b01, "rne_tiny");
    conv32(32'h00000001, 3'b011, 1'b0, 32'h00000000, 2'b00, "denorm");
    conv32(32'h80000000, 3'b000, 1'b0, 32'h00000000, 2'b00, "neg_zero");
    conv32(32'h4F000000, 3'b000, 1'b0, 32'h7FFFFFFF, 2'b10, "s_2p31");
    conv32(32'hCF000000, 3'b000, 1'b0, 32'h80000000, 2'b00, "s_m2p31");
    conv32(32'hCF000001, 3'b000, 1'b0, 32'h80000000, 2'b10, "s_below_min");
    conv32(32'h7FC00000, 3'b000, 1'b0, 32'h7FFFFFFF, 2'b10, "s_nan");
    conv32(32'hFF800000, 3'b000, 1'b0, 32'h80000000, 2'b10, "s_minf");
    conv32(32'h4F000000, 3'b000, 1'b1, 32'h80000000, 2'b00, "u_2p31");
    conv32(32'h4F7FFFFF, 3'b000, 1'b1, 32'hFFFFFF00, 2'b00, "u_maxfin");
    conv32(32'h4F800000, 3'b000, 1'b1, 32'hFFFFFFFF, 2'b10, "u_2p32");
    conv32(32'h7F800000, 3'b000, 1'b1, 32'hFFFFFFFF, 2'b10, "u_inf");
    conv32(32'h7FC00000, 3'b000, 1'b1, 32'hFFFFFFFF, 2'b10, "u_nan");
    conv32(32'hBF800000, 3'b000, 1'b1, 32'h00000000, 2'b10, "u_m1");
    conv32(32'hBECCCCCD, 3'b001, 1'b1, 32'h00000000, 2'b01, "u_m0p4_rtz");
    conv32(32'hBECCCCCD, 3'b010, 1'b1, 32'h00000000, 2'b10, "u_m0p4_rdn");

    // 64-bit, single stage
    conv64(32'h5F800000, 3'b000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 2'b10, "u64_2p64");
    conv64(32'h5F000000, 3'b000, 1'b1, 64'h8000000000000000, 2'b00, "u64_2p63");
    conv64(32'h5F000000, 3'b000, 1'b0, 64'h7FFFFFFFFFFFFFFF, 2'b10, "s64_2p63");
    conv64(32'hDF000000, 3'b000, 1'b0, 64'h8000000000000000, 2'b00, "s64_m2p63");
    conv64(32'hC0200000, 3'b000, 1'b0, 64'hFFFFFFFFFFFFFFFE, 2'b01, "s64_m2p5");

    // Streaming with a consumer stall on cycles 3..6
    idx = 0; nout = 0; first_out = -1;
    stalled_prev = 1'b0; saw_block = 1'b0; y_hold = '0;
    for (int c = 0; c < 40 && nout < 8; c++) begin
      @(negedge clk);
      or_a = !(c >= 3 && c <= 6);
      iv_a = (idx < 8);
      x_a  = ops[(idx < 8) ? idx : 7];
      rm_a = 3'b000; u_a = 1'b0;
      #1;
      if (!rdy_a) saw_block = 1'b1;
      if (ov_a && first_out < 0) first_out = c;
      if (stalled_prev) begin
        chk("stall_valid", 64'(ov_a), 64'd1);
        chk("stall_y", 64'(y_a), 64'(y_hold));
      end
      stalled_prev = ov_a && !or_a;
      y_hold = y_a;
      if (ov_a && or_a) begin
        chk("stream_y", 64'(y_a), 64'(nout + 1));
        nout++;
      end
      if (iv_a && rdy_a) idx++;
    end
    iv_a = 1'b0; or_a = 1'b1;
    chk("stream_count", 64'(nout), 64'd8);
    chk("stream_accepted", 64'(idx), 64'd8);
    chk("stream_blocked", 64'(saw_block), 64'd1);
    chk("first_latency", 64'(first_out), 64'd2);
    @(negedge clk);
    chk("stream_drained", 64'(ov_a), 64'd0);

    // Reset with two operands in flight
    @(negedge clk);
    x_a = 32'h40400000; iv_a = 1'b1; or_a = 1'b1;
    @(negedge clk);
    x_a = 32'h40800000;
    @(negedge clk);
    iv_a = 1'b0;
    chk("pre_rst_valid", 64'(ov_a), 64'd1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_ov", 64'(ov_a), 64'd0);
    chk("mid_rst_y", 64'(y_a), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("post_rst_rdy", 64'(rdy_a), 64'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("no_stale", 64'(ov_a), 64'd0);
    end
    conv32(32'h41100000, 3'b000, 1'b0, 32'h00000009, 2'b00, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
